stopwatch_core: RTL and testbench
=================================

// Module: stopwatch_core
// PURPOSE
//   Stopwatch timebase and BCD time counter, MM:SS.cc format, range 00:00.00-59:59.99.
//   Sits directly upstream of the 7-segment display controller.
//   Drives its six BCD digit inputs d..i.
//   Converts start/lap button levels into a run/pause/lap/clear FSM.
// PARAMETERS
//   CLK_HZ   50_000_000  system clock frequency in Hz
//   TICK_HZ  100         count rate (centiseconds); PRESCALE = CLK_HZ/TICK_HZ, must divide exactly
// PORTS
//   clk         in   1  system clock, rising edge
//   hard_reset  in   1  asynchronous, active-low reset
//   btn_start   in   1  start/stop button level, already debounced, asynchronous to clk
//   btn_lap     in   1  lap/clear button level, already debounced, asynchronous to clk
//   d,e         out  4  minutes tens / units (BCD)
//   f,g         out  4  seconds tens / units (BCD)
//   h,i         out  4  centiseconds tens / units (BCD)
//   running     out  1  1 in RUN or LAP
//   overflow    out  1  sticky; set on wrap 59:59.99 -> 00:00.00
// BEHAVIOUR
//   Reset (hard_reset=0): asynchronous; all digits 0, running=0, overflow=0, prescaler=0, FSM=IDLE.
//   Input path: each button goes through a 2-FF synchroniser, then rising-edge detect.
//     Result is a 1-cycle pulse; FSM acts 3 clk after the input rises.
//   Prescaler: counts 0..PRESCALE-1 only in RUN/LAP; tick pulse when value = PRESCALE-1.
//     Holds its value in PAUSE, so the fraction is kept.
//     Cleared on entry to IDLE.
//   Counter: on each tick, cs units 0-9, cs tens 0-9, s units 0-9, s tens 0-5,
//     m units 0-9, m tens 0-5; ripple-carry within the same cycle.
//     All six wrap to 0 at 59:59.99 and overflow is set in that cycle.
//   FSM states: IDLE, RUN, PAUSE, LAP.
//     IDLE : start -> RUN.
//     RUN  : start -> PAUSE; lap -> LAP (capture live count into hold register).
//     LAP  : count continues, outputs show hold register.
//            lap -> RUN (outputs show live count next cycle); start -> PAUSE (outputs show live count).
//     PAUSE: start -> RUN; lap -> IDLE (count and overflow cleared).
//   Simultaneous start and lap pulses: start wins; lap is ignored that cycle.
//   Outputs are registered and update in the cycle after a tick or capture.
//     Digits are always valid BCD (0-9; tens of minutes and seconds 0-5).
//   Tick coinciding with a lap capture: the captured value is the pre-increment count.
// CONFIGURATION
//   STOPWATCH_LAP_EN defined: LAP state and hold register present, as above.
//   STOPWATCH_LAP_EN undefined: no hold register; lap in RUN ignored; LAP unreachable.
//     Lap in PAUSE still clears; outputs always show the live count.
// STRUCTURE
//   Package stopwatch_pkg:
//     FSM state encoding (IDLE/RUN/PAUSE/LAP)
//     digit limit constants (9, 5)
//     BCD digit width (4)
//   Sub-module bcd_digit: one BCD digit with parameter MAX, inputs inc and clr, outputs q and carry.
//     Instantiated 6x as a chain.
// TESTING (CLK_HZ=1000, TICK_HZ=100 -> PRESCALE=10)
//   1. Reset held, then released -> all digits 0, running=0, overflow=0; 50 clk later, no change.
//   2. Start pulse, then 1000 clk -> d,e,f,g,h,i = 0,0,0,1,0,0; running=1.
//   3. Run 360000 ticks -> digits wrap to 0,0,0,0,0,0 and overflow=1.
//      Start then lap (clear) -> overflow=0, IDLE.
//   4. Lap at 00:00.50 -> outputs frozen at 0,0,0,0,5,0 while the count continues.
//      Lap at live 00:01.20 -> outputs show 0,0,0,1,2,0.
//   5. Start and lap rising in the same cycle during RUN -> PAUSE, no capture, digits frozen.
//      Prescaler resumes from its held value on the next start.
//   6. hard_reset pulled low mid-RUN at 00:03.47 -> digits 0 without waiting for a clk edge; IDLE after release.
//   7. Build without STOPWATCH_LAP_EN: lap in RUN has no effect; lap in PAUSE clears.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timebase: FSM encoding, BCD digit
// width, per-digit wrap limits and the packed MM:SS.cc time record.
package stopwatch_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_t;

    localparam bcd_t MAX_NINE = 4'd9;
    localparam bcd_t MAX_FIVE = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } sw_state_t;

    // Most significant digit first, matching the display order d..i.
    typedef struct packed {
        bcd_t m_t;
        bcd_t m_u;
        bcd_t s_t;
        bcd_t s_u;
        bcd_t c_t;
        bcd_t c_u;
    } sw_time_t;

endpackage

// File: rtl/stopwatch_if.sv
// Button and display bundle between the stopwatch core and its surroundings.
// master: the stopwatch core (drives digits/status); slave: buttons source and display side.
interface stopwatch_if;
    import stopwatch_pkg::*;

    logic btn_start;
    logic btn_lap;
    bcd_t d;
    bcd_t e;
    bcd_t f;
    bcd_t g;
    bcd_t h;
    bcd_t i;
    logic running;
    logic overflow;

    modport master (
        input  btn_start, btn_lap,
        output d, e, f, g, h, i, running, overflow
    );

    modport slave (
        output btn_start, btn_lap,
        input  d, e, f, g, h, i, running, overflow
    );

endinterface

// File: rtl/stopwatch_bcd_digit.sv
// One BCD counter digit wrapping at MAX; carry is combinational so a whole chain
// of digits ripples within a single clock cycle.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter bcd_t MAX = MAX_NINE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output bcd_t q,
    output logic carry
);

    bcd_t q_nxt;

    // >= rather than == keeps the digit inside its legal range even from a corrupted value.
    assign carry = inc && (q >= MAX);

    always_comb begin
        q_nxt = q;
        if (clr) begin
            q_nxt = '0;
        end else if (inc) begin
            q_nxt = (q >= MAX) ? '0 : q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= q_nxt;
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch timebase, MM:SS.cc BCD counter and run/pause/lap/clear FSM.
// Optional lap hold register built only when STOPWATCH_LAP_EN is defined.
//
//   state | meaning
//   IDLE  | cleared, prescaler and count at zero, waiting for start
//   RUN   | counting, display shows live count
//   PAUSE | stopped, count and prescaler fraction held
//   LAP   | counting, display shows captured lap time
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 100
) (
    input  logic clk,
    input  logic hard_reset,
    stopwatch_if.master sw
);

    // CLK_HZ must be an exact multiple of TICK_HZ.
    localparam int unsigned PRESCALE = CLK_HZ / TICK_HZ;
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [2:0] start_sync;
    logic [2:0] lap_sync;
    logic       start_pulse;
    logic       lap_pulse;

    sw_state_t  state;
    sw_state_t  state_nxt;
    logic       clear_cnt;
    logic       counting;
    logic       tick;
    logic [PS_W-1:0] presc;

    bcd_t q_cu, q_ct, q_su, q_st, q_mu, q_mt;
    logic c_cu, c_ct, c_su, c_st, c_mu, c_mt;
    logic overflow_q;
    sw_time_t live;
    sw_time_t shown;

    // Two flops resynchronise, the third gives the rising-edge reference.
    always_ff @(posedge clk or negedge hard_reset) begin
        if (!hard_reset) begin
            start_sync <= '0;
            lap_sync   <= '0;
        end else begin
            start_sync <= {start_sync[1:0], sw.btn_start};
            lap_sync   <= {lap_sync[1:0], sw.btn_lap};
        end
    end

    assign start_pulse = start_sync[1] & ~start_sync[2];
    assign lap_pulse   = lap_sync[1] & ~lap_sync[2];

    always_ff @(posedge clk or negedge hard_reset) begin
        if (!hard_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic capture;
`endif

    // Start takes priority over lap when both pulses land in the same cycle.
    always_comb begin
        state_nxt = state;
        clear_cnt = 1'b0;
`ifdef STOPWATCH_LAP_EN
        capture   = 1'b0;
`endif
        unique case (state)
            ST_IDLE: begin
                if (start_pulse) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (start_pulse) begin
                    state_nxt = ST_PAUSE;
                end
`ifdef STOPWATCH_LAP_EN
                else if (lap_pulse) begin
                    state_nxt = ST_LAP;
                    capture   = 1'b1;
                end
`endif
            end
            ST_LAP: begin
                if (start_pulse) begin
                    state_nxt = ST_PAUSE;
                end else if (lap_pulse) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (start_pulse) begin
                    state_nxt = ST_RUN;
                end else if (lap_pulse) begin
                    state_nxt = ST_IDLE;
                    clear_cnt = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign counting = (state == ST_RUN) || (state == ST_LAP);
    assign tick     = counting && (presc == PS_LAST);

    // Prescaler holds in PAUSE so a resumed run keeps the partial centisecond.
    always_ff @(posedge clk or negedge hard_reset) begin
        if (!hard_reset) begin
            presc <= '0;
        end else if (clear_cnt || tick) begin
            presc <= '0;
        end else if (counting) begin
            presc <= presc + PS_W'(1);
        end
    end

    bcd_digit #(.MAX(MAX_NINE)) u_cs_u (
        .clk(clk), .rst_n(hard_reset), .inc(tick), .clr(clear_cnt), .q(q_cu), .carry(c_cu)
    );
    bcd_digit #(.MAX(MAX_NINE)) u_cs_t (
        .clk(clk), .rst_n(hard_reset), .inc(c_cu), .clr(clear_cnt), .q(q_ct), .carry(c_ct)
    );
    bcd_digit #(.MAX(MAX_NINE)) u_s_u (
        .clk(clk), .rst_n(hard_reset), .inc(c_ct), .clr(clear_cnt), .q(q_su), .carry(c_su)
    );
    bcd_digit #(.MAX(MAX_FIVE)) u_s_t (
        .clk(clk), .rst_n(hard_reset), .inc(c_su), .clr(clear_cnt), .q(q_st), .carry(c_st)
    );
    bcd_digit #(.MAX(MAX_NINE)) u_m_u (
        .clk(clk), .rst_n(hard_reset), .inc(c_st), .clr(clear_cnt), .q(q_mu), .carry(c_mu)
    );
    bcd_digit #(.MAX(MAX_FIVE)) u_m_t (
        .clk(clk), .rst_n(hard_reset), .inc(c_mu), .clr(clear_cnt), .q(q_mt), .carry(c_mt)
    );

    assign live = {q_mt, q_mu, q_st, q_su, q_ct, q_cu};

    // A carry out of the top digit is exactly the 59:59.99 -> 00:00.00 wrap.
    always_ff @(posedge clk or negedge hard_reset) begin
        if (!hard_reset) begin
            overflow_q <= 1'b0;
        end else if (clear_cnt) begin
            overflow_q <= 1'b0;
        end else if (c_mt) begin
            overflow_q <= 1'b1;
        end
    end

`ifdef STOPWATCH_LAP_EN
    sw_time_t hold;

    // Sampled before the digit flops update, so a coincident tick is not included.
    always_ff @(posedge clk or negedge hard_reset) begin
        if (!hard_reset) begin
            hold <= '0;
        end else if (capture) begin
            hold <= live;
        end
    end

    assign shown = (state == ST_LAP) ? hold : live;
`else
    assign shown = live;
`endif

    assign sw.d        = shown.m_t;
    assign sw.e        = shown.m_u;
    assign sw.f        = shown.s_t;
    assign sw.g        = shown.s_u;
    assign sw.h        = shown.c_t;
    assign sw.i        = shown.c_u;
    assign sw.running  = counting;
    assign sw.overflow = overflow_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core (CLK_HZ=1000, TICK_HZ=100): directed steps plus
// random button activity, compared every cycle against a centisecond-count reference model.
module tb_stopwatch_core;

    localparam int PRESCALE = 10;
    localparam int WRAP_CS  = 360000;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_LAP   = 3;

    logic clk;
    logic hard_reset;
    stopwatch_if sw_if ();

    stopwatch_core #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
        .clk(clk),
        .hard_reset(hard_reset),
        .sw(sw_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: elapsed centiseconds as a plain integer.
    int m_mode;
    int m_cnt;
    int m_frac;
    int m_hold;
    bit m_ovf;
    bit in_reset;

    function automatic void model_reset();
        m_mode = M_IDLE;
        m_cnt  = 0;
        m_frac = 0;
        m_hold = 0;
        m_ovf  = 1'b0;
    endfunction

    function automatic void model_edge(input bit sp, input bit lp);
        bit cnt_on;
        bit tk;
        bit cap;
        bit clr;
        int nm;
        if (in_reset) return;
        cnt_on = (m_mode == M_RUN) || (m_mode == M_LAP);
        tk     = cnt_on && (m_frac == PRESCALE - 1);
        nm     = m_mode;
        cap    = 1'b0;
        clr    = 1'b0;
        if (sp) begin
            nm = (m_mode == M_RUN || m_mode == M_LAP) ? M_PAUSE : M_RUN;
        end else if (lp) begin
            if (m_mode == M_RUN && LAP_EN) begin
                nm  = M_LAP;
                cap = 1'b1;
            end else if (m_mode == M_LAP) begin
                nm = M_RUN;
            end else if (m_mode == M_PAUSE) begin
                nm  = M_IDLE;
                clr = 1'b1;
            end
        end
        if (cnt_on) m_frac = tk ? 0 : m_frac + 1;
        if (cap) m_hold = m_cnt;
        if (tk) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == WRAP_CS) begin
                m_cnt = 0;
                m_ovf = 1'b1;
            end
        end
        if (clr) begin
            m_cnt  = 0;
            m_frac = 0;
            m_ovf  = 1'b0;
        end
        m_mode = nm;
    endfunction

    function automatic logic [25:0] pack_time(input bit run, input bit ovf, input int cs);
        int mm;
        int ss;
        int cc;
        mm = cs / 6000;
        ss = (cs / 100) % 60;
        cc = cs % 100;
        return {run, ovf, 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10),
                4'(cc / 10), 4'(cc % 10)};
    endfunction

    function automatic logic [25:0] model_vec();
        bit run;
        run = (m_mode == M_RUN) || (m_mode == M_LAP);
        return pack_time(run, m_ovf, (m_mode == M_LAP) ? m_hold : m_cnt);
    endfunction

    task automatic check(input string tag, input logic [25:0] exp);
        logic [25:0] obs;
        obs = {sw_if.running, sw_if.overflow, sw_if.d, sw_if.e, sw_if.f, sw_if.g,
               sw_if.h, sw_if.i};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; advances one posedge and checks at the following negedge.
    task automatic step(input bit sp, input bit lp);
        @(posedge clk);
        model_edge(sp, lp);
        @(negedge clk);
        check("cycle", model_vec());
    endtask

    // Button raised just after a negedge is acted on at the third rising edge.
    task automatic press(input bit sp, input bit lp);
        sw_if.btn_start = sp;
        sw_if.btn_lap   = lp;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(sp, lp);
        sw_if.btn_start = 1'b0;
        sw_if.btn_lap   = 1'b0;
        repeat (3) step(1'b0, 1'b0);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0);
    endtask

    task automatic wait_cnt(input int target, input int frac, input int budget);
        int k;
        k = 0;
        while (!(m_cnt == target && m_frac == frac) && k < budget) begin
            step(1'b0, 1'b0);
            k++;
        end
        if (!(m_cnt == target && m_frac == frac)) begin
            miscompares++;
            $error("FAIL wait_cnt timeout target=%0d reached=%0d", target, m_cnt);
        end
    endtask

    task automatic sync_reset();
        hard_reset = 1'b0;
        in_reset   = 1'b1;
        model_reset();
        run(3);
        hard_reset = 1'b1;
        in_reset   = 1'b0;
        run(2);
    endtask

    initial begin
        hard_reset      = 1'b0;
        in_reset        = 1'b1;
        sw_if.btn_start = 1'b0;
        sw_if.btn_lap   = 1'b0;
        model_reset();
        @(negedge clk);
        run(4);
        check("reset_state", 26'h0);
        hard_reset = 1'b1;
        in_reset   = 1'b0;
        run(50);
        check("idle_50clk", 26'h0);

        // One second after start.
        press(1'b1, 1'b0);
        run(997);
        check("one_second", pack_time(1'b1, 1'b0, 100));

        // Pause, preload 59:59.99, resume across the wrap, then clear.
        press(1'b1, 1'b0);
        force dut.u_cs_u.q = 4'd9;
        force dut.u_cs_t.q = 4'd9;
        force dut.u_s_u.q  = 4'd9;
        force dut.u_s_t.q  = 4'd5;
        force dut.u_m_u.q  = 4'd9;
        force dut.u_m_t.q  = 4'd5;
        m_cnt = WRAP_CS - 1;
        step(1'b0, 1'b0);
        release dut.u_cs_u.q;
        release dut.u_cs_t.q;
        release dut.u_s_u.q;
        release dut.u_s_t.q;
        release dut.u_m_u.q;
        release dut.u_m_t.q;
        run(2);
        check("max_time_paused", pack_time(1'b0, 1'b0, WRAP_CS - 1));
        press(1'b1, 1'b0);
        wait_cnt(0, 0, 40);
        check("wrap_overflow", pack_time(1'b1, 1'b1, 0));
        run($urandom_range(5, 60));
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        check("clear_after_wrap", 26'h0);

        // Simultaneous start+lap in RUN pauses without capture; fraction survives.
        press(1'b1, 1'b0);
        wait_cnt(300, 4, 4000);
        press(1'b1, 1'b1);
        check("both_pause", pack_time(1'b0, 1'b0, 300));
        run($urandom_range(3, 40));
        check("both_frozen", pack_time(1'b0, 1'b0, 300));
        press(1'b1, 1'b0);
        check("resume_fraction", pack_time(1'b1, 1'b0, 301));
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        check("clear_idle", 26'h0);

`ifdef STOPWATCH_LAP_EN
        press(1'b1, 1'b0);
        wait_cnt(50, 0, 1000);
        press(1'b0, 1'b1);
        check("lap_capture", pack_time(1'b1, 1'b0, 50));
        run($urandom_range(20, 100));
        check("lap_frozen", pack_time(1'b1, 1'b0, 50));
        wait_cnt(120, 0, 1000);
        press(1'b0, 1'b1);
        check("lap_release", pack_time(1'b1, 1'b0, 120));
        wait_cnt(150, 7, 1000);
        press(1'b0, 1'b1);
        check("lap_tick_coincide", pack_time(1'b1, 1'b0, 150));
        press(1'b0, 1'b1);
`else
        press(1'b1, 1'b0);
        wait_cnt(30, 0, 1000);
        press(1'b0, 1'b1);
        wait_cnt(40, 0, 1000);
        check("lap_ignored", pack_time(1'b1, 1'b0, 40));
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        check("lap_clears", 26'h0);
`endif

        // Random button traffic against the model.
        for (int n = 0; n < 30; n++) begin
            int act;
            run($urandom_range(0, 150));
            act = $urandom_range(0, 3);
            case (act)
                0: press(1'b1, 1'b0);
                1: press(1'b0, 1'b1);
                2: press(1'b1, 1'b1);
                default: run(1);
            endcase
        end

        // Asynchronous reset mid-RUN at 00:03.47.
        sync_reset();
        press(1'b1, 1'b0);
        wait_cnt(347, 0, 4000);
        check("before_async_rst", pack_time(1'b1, 1'b0, 347));
        #2;
        hard_reset = 1'b0;
        in_reset   = 1'b1;
        model_reset();
        #1;
        check("async_rst_no_edge", 26'h0);
        @(negedge clk);
        run(2);
        hard_reset = 1'b1;
        in_reset   = 1'b0;
        run(20);
        check("idle_after_rst", 26'h0);
        press(1'b1, 1'b0);
        run(25);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
